mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end between the MEM-stage control and the word-addressed data memory (256 x 32, combinational read, write on posedge clk).
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Sub-word stores are done as read-modify-write over two cycles.
- Loads return a registered, extended result; the unit asserts busy while an access is in flight.

Parameters:
- ADDR_W, 8, word-index width driven to data memory (2^ADDR_W words).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe; accepted when req_ready=1
- req_ready  out  1  high in IDLE only
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and LW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half taken from low bits
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse with load_data
- misalign  out  1  one-cycle pulse, feature-dependent
- dmem_address  out  32  word index, zero-extended from addr[ADDR_W+1:2]
- dmem_data_in  out  32  word to write
- dmem_mem_write  out  1  write enable
- dmem_mem_read  out  1  read enable
- dmem_data_out  in  32  combinational read data from memory

Behaviour:
- States:
  - IDLE: accept on req_valid; latch addr, wdata, size, unsigned, we.
    - Next state: load -> LOAD; word store -> ST_WORD; byte/half store -> RMW_RD.
  - LOAD: dmem_mem_read=1 for one cycle; dmem_data_out captured at the cycle-ending edge; -> IDLE.
  - ST_WORD: dmem_mem_write=1, dmem_data_in=latched wdata; -> IDLE.
  - RMW_RD: dmem_mem_read=1; old word captured into merge register; -> RMW_WR.
  - RMW_WR: dmem_mem_write=1, dmem_data_in=merged word; -> IDLE.
- Memory-side outputs are decoded from state and latched regs only, never from req_* inputs.
- Outside the active state, dmem_mem_read, dmem_mem_write and dmem_data_in are 0.
- Address bits above ADDR_W+1 are ignored (wrap modulo 2^ADDR_W words).
- Byte order: little-endian.
  - Byte k at addr[1:0]=k occupies bits 8k+7:8k.
  - Halfword at addr[1]=h occupies bits 16h+15:16h.
- Load extension:
  - Signed byte/half: sign bit replicated to bit 31.
  - Unsigned: zero-filled.
  - Word: unmodified.
- RMW merge: only the selected byte/half lanes are replaced by wdata[7:0] or wdata[15:0]; other lanes keep the old word.
- Latency:
  - Load accepted at edge N -> load_valid high during cycle N+2.
  - req_ready high again in cycle N+2, so a back-to-back request is accepted at the edge ending N+2.
  - Word store: one busy cycle. Sub-word store: two busy cycles.
- load_data holds its value until the next load completes; load_valid is a single pulse.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- Reset values: state IDLE; req_ready=1; load_data=0; load_valid=0; misalign=0; all dmem_* outputs 0.
- Reset mid-operation: rst_n low forces IDLE asynchronously.
  - dmem_mem_write drops immediately.
  - A pending RMW write is discarded, never partially written.
  - No load_valid is issued for the aborted load.

Optional Feature:
- Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is accepted, does no memory access, pulses misalign in the following cycle, and returns to IDLE.
  - No load_valid is issued; no write occurs.
- Undefined:
  - Offending low address bits are forced to zero (aligned down) and the access proceeds normally.
  - misalign is tied 0.

Test Plan:
- Reset: hold rst_n=0 -> all outputs 0 and req_ready=1. Assert rst_n=0 during RMW_RD -> no write occurs; word unchanged.
- Word round trip: SW 0xDEADBEEF to addr 0x10 -> one write to word 4. LW addr 0x10 -> load_valid two cycles after accept with 0xDEADBEEF.
- Sub-word store: word 4 = 0x11223344; SB 0xAA to addr 0x13 -> word 4 = 0xAA223344. SH 0xBEEF to addr 0x10 -> 0xAA22BEEF. Each store is busy for exactly 2 cycles.
- Load extension: word 4 = 0x80FF7F01.
  - LB addr 0x12 -> 0xFFFFFFFF; LBU addr 0x12 -> 0x000000FF.
  - LH addr 0x12 -> 0xFFFF80FF; LHU addr 0x12 -> 0x000080FF.
  - LB addr 0x11 -> 0x0000007F.
- Back-to-back: SW, LW, SB, LW with req_valid held high -> each accepted only while req_ready=1. Final LW returns the merged word; no requests are dropped.
- Misalign: LW addr 0x12.
  - Macro on: misalign pulse, no dmem access, no load_valid.
  - Macro off: reads word 4 (addr 0x10), misalign stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front-end onto a word-addressed data memory.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_data_in,
  output logic        dmem_mem_write,
  output logic        dmem_mem_read,
  input  logic [31:0] dmem_data_out
);
  typedef enum logic [2:0] {IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, MIS} state_t;
  state_t state, next;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q, merge_q, ext, merged, mask, lanes, bsh, hsh;
  logic [1:0] size_q;
  logic uns_q, bad, unused_bits;
  assign unused_bits = ^req_addr[31:ADDR_W+2];
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign bad = req_size[1] ? (req_addr[1:0] != 2'b00) : (req_size[0] & req_addr[0]);
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    if (state == IDLE)
      next = !req_valid ? IDLE : bad ? MIS : !req_we ? LOAD : req_size[1] ? ST_WORD : RMW_RD;
    else if (state == RMW_RD)
      next = RMW_WR;
  end
  always_comb begin
    req_ready      = state == IDLE;
    misalign       = state == MIS;
    dmem_mem_read  = state == LOAD || state == RMW_RD;
    dmem_mem_write = state == ST_WORD || state == RMW_WR;
    dmem_data_in   = state == ST_WORD ? wdata_q : state == RMW_WR ? merge_q : 32'h0;
  end
  assign dmem_address = {{(30-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  // Half accesses only look at addr[1], so an odd half address is aligned down implicitly.
  assign bsh = dmem_data_out >> {addr_q[1:0], 3'b000};
  assign hsh = dmem_data_out >> {addr_q[1], 4'b0000};
  assign ext = size_q[1] ? dmem_data_out
             : size_q[0] ? {{16{~uns_q & hsh[15]}}, hsh[15:0]}
             : {{24{~uns_q & bsh[7]}}, bsh[7:0]};
  assign mask   = size_q[0] ? 32'h0000FFFF << {addr_q[1], 4'b0000} : 32'h000000FF << {addr_q[1:0], 3'b000};
  assign lanes  = size_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign merged = (dmem_data_out & ~mask) | (lanes & mask);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      merge_q    <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
      end
      if (state == RMW_RD) merge_q <= merged;
      if (state == LOAD) load_data <= ext;
      load_valid <= state == LOAD;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus with a load-result scoreboard checked by a separate monitor.
module tb_mem_access_unit;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic req_ready, load_valid, misalign, dmem_mem_write, dmem_mem_read;
  logic [31:0] load_data, dmem_address, dmem_data_in, dmem_data_out;
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] exp_q [$];
  int checks = 0, errors = 0, wr_cnt = 0, rd_cnt = 0, acc_cnt = 0;

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_data(load_data), .load_valid(load_valid), .misalign(misalign),
    .dmem_address(dmem_address), .dmem_data_in(dmem_data_in), .dmem_mem_write(dmem_mem_write),
    .dmem_mem_read(dmem_mem_read), .dmem_data_out(dmem_data_out)
  );

  always #5 clk = ~clk;
  assign dmem_data_out = mem[dmem_address[7:0]];
  always @(posedge clk) begin
    if (dmem_mem_write) begin
      mem[dmem_address[7:0]] <= dmem_data_in;
      wr_cnt++;
    end
    if (dmem_mem_read) rd_cnt++;
    if (rst_n && req_valid && req_ready) acc_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && load_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load_valid got %h expected none", load_data);
      end else begin
        e = exp_q.pop_front();
        chk("load_data", load_data, e);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic busy(input string name, input int want);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, want);
  endtask

  task automatic st(input string name, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int cyc);
    issue(1'b1, sz, 1'b0, a, d);
    req_valid = 1'b0;
    busy(name, cyc);
  endtask

  task automatic ld(input string name, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    issue(1'b0, sz, uns, a, 32'h0);
    req_valid = 1'b0;
    busy(name, 1);
    chk({name, "_latency"}, load_valid, 1);
  endtask

  initial begin
    int w, r, acc;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {load_data, load_valid, misalign, dmem_mem_write, dmem_mem_read}, 0);
    chk("rst_dmem", dmem_address | dmem_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    w = wr_cnt;
    st("sw_busy", 2'b10, 32'h10, 32'hDEADBEEF, 1);
    chk("sw_writes", wr_cnt - w, 1);
    chk("sw_word4", mem[4], 32'hDEADBEEF);
    ld("lw_busy", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

    st("sw2_busy", 2'b10, 32'h10, 32'h11223344, 1);
    st("sb_busy", 2'b00, 32'h13, 32'h000000AA, 2);
    chk("sb_word4", mem[4], 32'hAA223344);
    st("sh_busy", 2'b01, 32'h10, 32'h0000BEEF, 2);
    chk("sh_word4", mem[4], 32'hAA22BEEF);

    st("sw3_busy", 2'b10, 32'h10, 32'h80FF7F01, 1);
    ld("lb12", 2'b00, 1'b0, 32'h12, 32'hFFFFFFFF);
    ld("lbu12", 2'b00, 1'b1, 32'h12, 32'h000000FF);
    ld("lh12", 2'b01, 1'b0, 32'h12, 32'hFFFF80FF);
    ld("lhu12", 2'b01, 1'b1, 32'h12, 32'h000080FF);
    ld("lb11", 2'b00, 1'b0, 32'h11, 32'h0000007F);
    ld("lw_wrap", 2'b10, 1'b0, 32'h00000410, 32'h80FF7F01);

    acc = acc_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304);
    exp_q.push_back(32'h01020304);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055);
    exp_q.push_back(32'h01025504);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_accepts", acc_cnt - acc, 4);
    chk("b2b_word8", mem[8], 32'h01025504);

    r = rd_cnt;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_pulse", misalign, 1);
    chk("mis_noread", dmem_mem_read, 0);
    @(negedge clk);
    chk("mis_single", misalign, 0);
    chk("mis_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    chk("mis_rdcnt", rd_cnt - r, 0);
`else
    exp_q.push_back(32'h80FF7F01);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_zero", misalign, 0);
    chk("mis_align_addr", dmem_address, 32'h4);
    @(negedge clk);
    chk("mis_lv", load_valid, 1);
    chk("mis_rdcnt", rd_cnt - r, 1);
`endif

    w = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h000000EE);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr", dmem_mem_write, 0);
    chk("midrst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_word8", mem[8], 32'h01025504);
    chk("midrst_writes", wr_cnt - w, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
